// File: rtl/serial_sub2.sv
// Digit-serial W-bit subtractor, 2 bits per cycle: diff = a - b - bin (mod 2^W), borrow out of MSB.
// Operands arrive and results leave over valid/ready handshakes; one operation in flight at a time.
//
//   state | meaning
//   IDLE  | in_ready high, waiting for operands
//   RUN   | one 2-bit digit per cycle, W/2 cycles
//   DONE  | out_valid high, result held until out_ready
module serial_sub2 #(
   parameter int W = 8
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] pa,
   input  logic [W-1:0] pb,
   input  logic         pbin,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] pdiff,
   output logic         pbout
);
   localparam int ND = W / 2;
   localparam int CW = (ND > 1) ? $clog2(ND) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t         state, state_nxt;
   logic [W-1:0]   sh_a, sh_b, res, res_nxt;
   logic           brw;
   logic [CW-1:0]  cnt;
   logic           last;
   logic [1:0]     d;
   logic           bo0, bo1;

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign last      = (cnt == CW'(ND - 1));

   // ripple borrow through the low digit: bit0 then bit1
   always_comb begin
      d[0]    = sh_a[0] ^ sh_b[0] ^ brw;
      bo0     = (~sh_a[0] & (sh_b[0] | brw)) | (sh_b[0] & brw);
      d[1]    = sh_a[1] ^ sh_b[1] ^ bo0;
      bo1     = (~sh_a[1] & (sh_b[1] | bo0)) | (sh_b[1] & bo0);
      res_nxt = (res >> 2) | (W'(d) << (W - 2));
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (in_valid)  state_nxt = RUN;
         RUN:     if (last)      state_nxt = DONE;
         DONE:    if (out_ready) state_nxt = IDLE;
         default:                state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sh_a  <= '0;
         sh_b  <= '0;
         res   <= '0;
         brw   <= 1'b0;
         cnt   <= '0;
         pdiff <= '0;
         pbout <= 1'b0;
      end else begin
         case (state)
            IDLE: if (in_valid) begin
               sh_a <= pa;
               sh_b <= pb;
               brw  <= pbin;
               cnt  <= '0;
            end
            RUN: begin
               sh_a <= sh_a >> 2;
               sh_b <= sh_b >> 2;
               brw  <= bo1;
               res  <= res_nxt;
               cnt  <= cnt + 1'b1;
               if (last) begin
                  pdiff <= res_nxt;
                  pbout <= bo1;
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_serial_sub2.sv
// Directed bench for serial_sub2: one W=8 instance for the main plan and one W=2 instance
// for the smallest legal width. Latencies count edges inclusive of the input handshake edge.
module tb_serial_sub2;
   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       in_valid = 1'b0, out_ready = 1'b0, pbin = 1'b0;
   logic [7:0] pa = '0, pb = '0;
   logic       in_ready, out_valid, pbout;
   logic [7:0] pdiff;

   logic       v2 = 1'b0, r2 = 1'b0, bin2 = 1'b0;
   logic [1:0] a2 = '0, b2 = '0;
   logic       rdy2, ov2, bout2;
   logic [1:0] diff2;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   always #5 clock = ~clock;

   serial_sub2 #(.W(8)) dut (
      .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .pa(pa), .pb(pb), .pbin(pbin), .out_valid(out_valid), .out_ready(out_ready),
      .pdiff(pdiff), .pbout(pbout)
   );

   serial_sub2 #(.W(2)) dut2 (
      .clock(clock), .reset(reset), .in_valid(v2), .in_ready(rdy2),
      .pa(a2), .pb(b2), .pbin(bin2), .out_valid(ov2), .out_ready(r2),
      .pdiff(diff2), .pbout(bout2)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
      cyc++;
   endtask

   // Offers one operand set, holds it until accepted, returns result and inclusive latency.
   task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic bin,
                        output logic [7:0] diff, output logic bout, output int lat);
      int guard;
      guard = 0;
      while (!in_ready && guard < 50) begin tick(); guard++; end
      chk("ready_before_op", 32'(in_ready), 32'd1);
      pa = a; pb = b; pbin = bin; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      chk("in_ready_drop", 32'(in_ready), 32'd0);
      lat = 1;
      while (!out_valid && lat < 20) begin tick(); lat++; end
      chk("out_valid_seen", 32'(out_valid), 32'd1);
      diff = pdiff;
      bout = pbout;
   endtask

   task automatic drain();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("out_valid_fall", 32'(out_valid), 32'd0);
      chk("in_ready_back", 32'(in_ready), 32'd1);
   endtask

   initial begin
      logic [7:0] d;
      logic       bo;
      logic [8:0] ref9;
      int         lat, guard, last_hs;

      #1;
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_pdiff", 32'(pdiff), 32'd0);
      chk("rst_pbout", 32'(pbout), 32'd0);
      tick(); tick();
      reset = 1'b0;
      tick();

      // basic: 0x5A - 0x23 = 0x37
      do_op(8'h5A, 8'h23, 1'b0, d, bo, lat);
      chk("t1_lat", 32'(lat), 32'd5);
      chk("t1_diff", 32'(d), 32'h37);
      chk("t1_bout", 32'(bo), 32'd0);
      drain();

      // wrap-around and borrow-in
      do_op(8'h00, 8'h01, 1'b0, d, bo, lat);
      chk("t2a_diff", 32'(d), 32'hFF);
      chk("t2a_bout", 32'(bo), 32'd1);
      drain();
      do_op(8'h10, 8'h0F, 1'b1, d, bo, lat);
      chk("t2b_diff", 32'(d), 32'h00);
      chk("t2b_bout", 32'(bo), 32'd0);
      drain();

      // backpressure in DONE with new operands already offered
      do_op(8'h80, 8'h01, 1'b0, d, bo, lat);
      pa = 8'h33; pb = 8'h11; pbin = 1'b0; in_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("t3_hold_diff", 32'(pdiff), 32'h7F);
         chk("t3_hold_bout", 32'(pbout), 32'd0);
         chk("t3_hold_busy", 32'(in_ready), 32'd0);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("t3_valid_fall", 32'(out_valid), 32'd0);
      chk("t3_ready_rise", 32'(in_ready), 32'd1);
      tick();
      in_valid = 1'b0;
      chk("t3_accepted", 32'(in_ready), 32'd0);
      guard = 0;
      while (!out_valid && guard < 20) begin tick(); guard++; end
      chk("t3_diff", 32'(pdiff), 32'h22);
      chk("t3_bout", 32'(pbout), 32'd0);
      drain();

      // asynchronous reset two cycles into RUN
      pa = 8'h44; pb = 8'h01; pbin = 1'b0; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick(); tick();
      #2 reset = 1'b1;
      #1;
      chk("t4_out_valid", 32'(out_valid), 32'd0);
      chk("t4_in_ready", 32'(in_ready), 32'd1);
      chk("t4_pdiff", 32'(pdiff), 32'd0);
      tick();
      reset = 1'b0;
      tick();
      do_op(8'hFF, 8'hFF, 1'b1, d, bo, lat);
      chk("t4_diff", 32'(d), 32'hFF);
      chk("t4_bout", 32'(bo), 32'd1);
      drain();

      // back-to-back stream against a 9-bit reference subtraction
      in_valid = 1'b1;
      out_ready = 1'b1;
      last_hs = -1;
      for (int i = 0; i < 1000; i++) begin
         pa = 8'($urandom); pb = 8'($urandom); pbin = 1'($urandom);
         ref9 = {1'b0, pa} - {1'b0, pb} - {8'd0, pbin};
         guard = 0;
         while (!in_ready && guard < 20) begin tick(); guard++; end
         chk("t5_ready", 32'(in_ready), 32'd1);
         if (last_hs >= 0) chk("t5_spacing", 32'(cyc - last_hs), 32'd6);
         last_hs = cyc;
         tick();
         guard = 0;
         while (!out_valid && guard < 20) begin tick(); guard++; end
         chk("t5_diff", 32'(pdiff), 32'(ref9[7:0]));
         chk("t5_bout", 32'(pbout), 32'(ref9[8]));
      end
      in_valid = 1'b0;
      tick();
      out_ready = 1'b0;

      // W=2: 1 - 2 = 3 with borrow
      a2 = 2'd1; b2 = 2'd2; bin2 = 1'b0; v2 = 1'b1;
      chk("t6_ready", 32'(rdy2), 32'd1);
      tick();
      v2 = 1'b0;
      lat = 1;
      while (!ov2 && lat < 10) begin tick(); lat++; end
      chk("t6_lat", 32'(lat), 32'd2);
      chk("t6_diff", 32'(diff2), 32'd3);
      chk("t6_bout", 32'(bout2), 32'd1);
      r2 = 1'b1;
      tick();
      r2 = 1'b0;
      chk("t6_done", 32'(ov2), 32'd0);
      a2 = 2'd3; b2 = 2'd1; bin2 = 1'b1; v2 = 1'b1;
      tick();
      v2 = 1'b0;
      guard = 0;
      while (!ov2 && guard < 10) begin tick(); guard++; end
      chk("t6b_diff", 32'(diff2), 32'd1);
      chk("t6b_bout", 32'(bout2), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
